// File: rtl/led_owner_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_arb_pkg
//  Description : Shared types and default constants for the LED bank owner
//                arbiter (controller state encoding, default parameter
//                values, requester index helper type).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package led_arb_pkg;

  localparam int C_NUM_REQ        = 4;
  localparam int C_LED_W          = 4;
  localparam int C_HOLD_CYCLES    = 50_000_000;
  localparam int C_HB_HALF_PERIOD = 25_000_000;

  // Requester index for the default configuration.
  typedef logic [$clog2(C_NUM_REQ)-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_t;

endpackage : led_arb_pkg
`default_nettype wire

// File: rtl/led_owner_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_owner_arbiter_if
//  Description : Requester-side bundle of the LED bank arbiter.
//  Signals     : req     - per-requester ownership request (level)
//                pattern - per-requester LED pattern
//                gnt     - one-hot (or zero) grant
//                leds    - LED drive
//                busy    - any grant active
//  Modports    : master (requesters / board), slave (arbiter)
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_owner_arbiter_if
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ = C_NUM_REQ,
  parameter int LED_W   = C_LED_W
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][LED_W-1:0] pattern;
  logic [NUM_REQ-1:0]            gnt;
  logic [LED_W-1:0]              leds;
  logic                          busy;

  modport master (
    output req,
    output pattern,
    input  gnt,
    input  leds,
    input  busy
  );

  modport slave (
    input  req,
    input  pattern,
    output gnt,
    output leds,
    output busy
  );

endinterface : led_owner_arbiter_if
`default_nettype wire

// File: rtl/led_owner_arbiter_picker.sv
`default_nettype none
// ============================================================================
//  Module      : led_rr_picker
//  Description : Combinational round-robin picker. Searches the request
//                vector starting just after the previous owner, wrapping
//                modulo NUM_REQ, and returns the first requester found.
//  Ports       : i_req        - request vector
//                i_last_owner - index of the most recent owner
//                o_pick       - index of the selected requester
//                o_valid      - a requester was found
//  Revision    : 1.0 - initial release
// ============================================================================
module led_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  wire logic [NUM_REQ-1:0]         i_req,
  input  wire logic [$clog2(NUM_REQ)-1:0] i_last_owner,
  output logic      [$clog2(NUM_REQ)-1:0] o_pick,
  output logic                            o_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // The previous owner is checked last (k == NUM_REQ), which is what pushes a
  // still-requesting preempted owner behind everybody else.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!o_valid && i_req[(int'(i_last_owner) + k) % NUM_REQ]) begin
        o_valid = 1'b1;
        o_pick  = IDX_W'((int'(i_last_owner) + k) % NUM_REQ);
      end
    end
  end

endmodule : led_rr_picker
`default_nettype wire

// File: rtl/led_owner_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : led_owner_arbiter
//  Description : Shares the board LED bank between on-chip requesters.
//                Round-robin arbitration with a guaranteed minimum ownership
//                time; a free-running heartbeat is shown on LED 0 whenever
//                nobody owns the bank.
//  Ports       : sys_clk_50m - system clock
//                sys_rst     - synchronous reset, active-high
//                bus         - requester bundle (slave side): req, pattern in;
//                              gnt, leds, busy out (all outputs registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module led_owner_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ        = C_NUM_REQ,
  parameter int LED_W          = C_LED_W,
  parameter int HOLD_CYCLES    = C_HOLD_CYCLES,
  parameter int HB_HALF_PERIOD = C_HB_HALF_PERIOD
) (
  input  wire logic          sys_clk_50m,
  input  wire logic          sys_rst,
  led_owner_arbiter_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int HB_W   = (HB_HALF_PERIOD > 1) ? $clog2(HB_HALF_PERIOD) : 1;

  localparam logic [HOLD_W-1:0] c_hold_load = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HB_W-1:0]   c_hb_reload = HB_W'(HB_HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0]  c_last_rst  = IDX_W'(NUM_REQ - 1);

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [LED_W-1:0]    r_leds;
  logic                r_busy;
  logic                r_hb;
  logic [HB_W-1:0]     r_hb_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [IDX_W-1:0]    r_last_owner;   // doubles as the current owner

  logic [IDX_W-1:0]    w_pick;
  logic                w_valid;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_owner_req;
  logic                w_other_req;

  led_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req        (bus.req),
    .i_last_owner (r_last_owner),
    .o_pick       (w_pick),
    .o_valid      (w_valid)
  );

  assign w_pick_oh   = NUM_REQ'(1) << w_pick;
  assign w_owner_oh  = NUM_REQ'(1) << r_last_owner;
  assign w_owner_req = |(bus.req & w_owner_oh);
  assign w_other_req = |(bus.req & ~w_owner_oh);

  always_ff @(posedge sys_clk_50m) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_leds       <= '0;
      r_busy       <= 1'b0;
      r_hb         <= 1'b0;
      r_hb_cnt     <= '0;
      r_hold_cnt   <= '0;
      r_last_owner <= c_last_rst;
    end else begin
      // Heartbeat runs in every state so its phase is unaffected by grants.
      if (r_hb_cnt == '0) begin
        r_hb     <= ~r_hb;
        r_hb_cnt <= c_hb_reload;
      end else begin
        r_hb_cnt <= r_hb_cnt - HB_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          r_leds <= LED_W'(r_hb);
          r_gnt  <= '0;
          r_busy <= 1'b0;
          if (w_valid) begin
            r_gnt        <= w_pick_oh;
            r_busy       <= 1'b1;
            r_last_owner <= w_pick;
            r_hold_cnt   <= c_hold_load;
            r_state      <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          r_leds <= bus.pattern[r_last_owner];
          if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
          if (!w_owner_req) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_hold_cnt == '0) begin
            r_state <= ST_OPEN;
          end
        end

        ST_OPEN: begin
          r_leds <= bus.pattern[r_last_owner];
          // Release and preemption both go back through one IDLE cycle.
          if (!w_owner_req || w_other_req) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.leds = r_leds;
  assign bus.busy = r_busy;

endmodule : led_owner_arbiter
`default_nettype wire

// File: tb/tb_led_owner_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_owner_arbiter
//  Description : Self-checking bench for led_owner_arbiter. A cycle model
//                predicts gnt/leds/busy for every driven cycle; predictions
//                are queued and compared after the clock edge. Directed
//                checks cover grant latency, hold length, rotation order,
//                release and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_owner_arbiter;

  localparam int NR   = 4;
  localparam int LW   = 4;
  localparam int HOLD = 8;
  localparam int HB   = 4;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [LW-1:0] leds;
    logic          busy;
  } exp_t;

  logic clk;
  logic rst;

  led_owner_arbiter_if #(.NUM_REQ(NR), .LED_W(LW)) u_bus ();

  led_owner_arbiter #(
    .NUM_REQ        (NR),
    .LED_W          (LW),
    .HOLD_CYCLES    (HOLD),
    .HB_HALF_PERIOD (HB)
  ) u_dut (
    .sys_clk_50m (clk),
    .sys_rst     (rst),
    .bus         (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur     = "init";
  exp_t  sb[$];

  // Model state: owner index (-1 = none), last owner, cycles since grant,
  // and edges elapsed since reset released.
  int m_owner = -1;
  int m_last  = NR - 1;
  int m_age   = 0;
  int m_n     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s_%s: got 0x%0h expected 0x%0h at %0t", cur, tag, obs, exp_v, $time);
    end
  endtask

  task automatic model(output exp_t e);
    int hb_now;
    bit found;
    e = '0;
    if (rst) begin
      m_owner = -1;
      m_last  = NR - 1;
      m_age   = 0;
      m_n     = 0;
    end else begin
      hb_now = ((m_n + HB - 1) / HB) % 2;
      if (m_owner < 0) begin
        e.leds = LW'(hb_now);
        found  = 1'b0;
        for (int k = 1; k <= NR; k++) begin
          if (!found && u_bus.req[(m_last + k) % NR]) begin
            found   = 1'b1;
            m_owner = (m_last + k) % NR;
          end
        end
        if (found) begin
          m_last = m_owner;
          m_age  = 0;
        end
      end else begin
        e.leds = u_bus.pattern[m_owner];
        if (!u_bus.req[m_owner]) begin
          m_owner = -1;
        end else if (m_age >= HOLD && (u_bus.req & ~(NR'(1) << m_owner)) != '0) begin
          m_owner = -1;
        end else begin
          m_age++;
        end
      end
      m_n++;
      if (m_owner >= 0) begin
        e.gnt  = NR'(1) << m_owner;
        e.busy = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [NR-1:0] rq);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst       = r;
    u_bus.req = rq;
    model(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("gnt",     32'(u_bus.gnt),            32'(got.gnt));
    chk("leds",    32'(u_bus.leds),           32'(got.leds));
    chk("busy",    32'(u_bus.busy),           32'(got.busy));
    chk("onehot0", 32'($onehot0(u_bus.gnt)),  32'd1);
  endtask

  logic [NR-1:0] log_g [0:49];
  int            rv    [0:15];
  int            rl    [0:15];
  int            nr;
  int            len;

  initial begin
    rst           = 1'b1;
    u_bus.req     = '0;
    u_bus.pattern[0] = 4'h5;
    u_bus.pattern[1] = 4'h3;
    u_bus.pattern[2] = 4'hA;
    u_bus.pattern[3] = 4'hC;

    // 1. reset and idle heartbeat
    cur = "t1";
    repeat (3) step(1'b1, '0);
    chk("rst_gnt", 32'(u_bus.gnt), 32'd0);
    repeat (12) step(1'b0, '0);

    // 2. single grant, pattern shown one clock after the grant
    cur = "t2";
    step(1'b0, 4'b0100);
    chk("lat_gnt", 32'(u_bus.gnt), 32'b0100);
    step(1'b0, 4'b0100);
    chk("lat_leds", 32'(u_bus.leds), 32'hA);
    repeat (12) step(1'b0, 4'b0100);
    chk("held", 32'(u_bus.gnt), 32'b0100);
    repeat (3) step(1'b0, '0);

    // 3. hold protection against a competing request
    cur = "t3";
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    len = 2;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0101);
      if (u_bus.gnt != 4'b0100) break;
      len++;
    end
    chk("len", 32'(len), 32'(HOLD + 1));
    chk("gap", 32'(u_bus.gnt), 32'd0);
    step(1'b0, 4'b0101);
    chk("next", 32'(u_bus.gnt), 32'b0001);
    repeat (2) step(1'b0, '0);

    // 4. full round-robin after a fresh reset
    cur = "t4";
    repeat (2) step(1'b1, '0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 4'b1111);
      log_g[i] = u_bus.gnt;
    end
    for (int i = 0; i < 16; i++) begin
      rv[i] = -1;
      rl[i] = 0;
    end
    nr = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 0 || log_g[i] != log_g[i-1]) begin
        if (nr < 16) begin
          rv[nr] = int'(log_g[i]);
          rl[nr] = 1;
        end
        nr++;
      end else if (nr <= 16) begin
        rl[nr-1]++;
      end
    end
    for (int j = 0; j < 5; j++) begin
      chk("order", 32'(rv[2*j]), 32'(1 << (j % 4)));
      if (j < 4) begin
        chk("glen",   32'(rl[2*j]),   32'(HOLD + 1));
        chk("gapval", 32'(rv[2*j+1]), 32'd0);
        chk("gaplen", 32'(rl[2*j+1]), 32'd1);
      end
    end
    repeat (3) step(1'b0, '0);

    // 5. voluntary release during hold
    cur = "t5";
    step(1'b0, 4'b0010);
    chk("gnt1", 32'(u_bus.gnt), 32'b0010);
    repeat (2) step(1'b0, 4'b0010);
    step(1'b0, '0);
    chk("rel", 32'(u_bus.gnt), 32'd0);
    repeat (8) step(1'b0, '0);
    chk("stay_idle", 32'(u_bus.busy), 32'd0);

    // 6. reset while requester 3 owns the bank
    cur = "t6";
    step(1'b0, 4'b1000);
    chk("gnt3", 32'(u_bus.gnt), 32'b1000);
    repeat (3) step(1'b0, 4'b1000);
    step(1'b1, 4'b1000);
    chk("rst_gnt", 32'(u_bus.gnt), 32'd0);
    chk("rst_leds", 32'(u_bus.leds), 32'd0);
    step(1'b0, 4'b1001);
    chk("first0", 32'(u_bus.gnt), 32'b0001);
    repeat (4) step(1'b0, 4'b1001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_led_owner_arbiter
`default_nettype wire

// File: doc/led_owner_arbiter.md
Name: led_owner_arbiter

Overview:
Shares the board LED bank between several on-chip requesters, such as the heartbeat blinker, button mirror logic and Nios PIO export. Arbitration is round-robin with a guaranteed minimum ownership time. When no requester owns the bank, a free-running heartbeat is shown on LED 0. Sits between the requesters and the top-level leds output.

Parameters:
NUM_REQ, 4, number of requesters (>= 2)
LED_W, 4, LED bank width (>= 1)
HOLD_CYCLES, 50_000_000, minimum ownership time in clocks before preemption (>= 1)
HB_HALF_PERIOD, 25_000_000, heartbeat half period in clocks (>= 1)

Ports:
sys_clk_50m  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester ownership request, level
pattern  in  NUM_REQ x LED_W  per-requester LED pattern, sampled every cycle
gnt  out  NUM_REQ  one-hot (or zero) grant, registered
leds  out  LED_W  LED drive, registered
busy  out  1  high while any grant is active

Behaviour:
- Single clock domain. Reset is synchronous and active-high on sys_rst.
- All outputs are registered and take reset values on the first edge with sys_rst=1:
  - gnt=0, leds=0, busy=0
  - state=IDLE, hb=0, hb_cnt=0, hold_cnt=0
  - last_owner=NUM_REQ-1, so requester 0 wins first.
- Reset mid-ownership drops the grant on the next edge; there is no drain.
- Widths:
  - hold_cnt is $clog2(HOLD_CYCLES+1) bits.
  - hb_cnt is $clog2(HB_HALF_PERIOD) bits, minimum 1.
  - Both counters count down and never underflow.
- Heartbeat:
  - hb_cnt runs continuously outside reset, in every state.
  - hb toggles and hb_cnt reloads HB_HALF_PERIOD-1 when hb_cnt==0.
  - Phase is therefore continuous across ownership changes.
- Picker:
  - Combinational over req.
  - Searches last_owner+1 ... last_owner+NUM_REQ, modulo NUM_REQ.
  - Returns the first set bit plus a valid flag.
- States:
  - IDLE:
    - gnt=0; leds <= {0, hb}, i.e. LED 0 = hb, others 0.
    - If valid: gnt <= onehot(pick), owner=last_owner=pick, hold_cnt <= HOLD_CYCLES-1, go to HOLD.
    - Grant latency is 1 clock from req being sampled high.
  - HOLD:
    - leds <= pattern[owner] each cycle, 1-clock latency.
    - hold_cnt decrements each cycle.
    - Other requests are ignored; no preemption.
    - req[owner]=0 → voluntary release: gnt <= 0, go to IDLE.
    - Else hold_cnt==0 → go to OPEN.
  - OPEN:
    - leds <= pattern[owner].
    - req[owner]=0 → gnt <= 0, go to IDLE.
    - Else any other req bit set → preempt: gnt <= 0, go to IDLE.
    - Else stay in OPEN.
- Every ownership change passes through exactly one IDLE cycle with gnt=0, so there is never a cycle with two grants.
- During that IDLE cycle the heartbeat is shown.
- Because last_owner was updated, a preempted owner that still requests re-queues behind all others.
- Simultaneous events:
  - Release and a new request in the same cycle: release is taken first, grant goes out after the IDLE cycle.
  - All NUM_REQ requesting: strict rotation 0,1,2,3,0...
- busy = |gnt, registered together with gnt.
- Invariant: $onehot0(gnt) always holds.

Decomposition:
- Package led_arb_pkg:
  - state enum (IDLE, HOLD, OPEN)
  - default parameter constants
  - idx_t = logic[$clog2(NUM_REQ)-1:0] helper
- Sub-module led_rr_picker (parameter NUM_REQ):
  - Inputs: req, last_owner.
  - Outputs: pick, valid.
  - Purely combinational; unit-testable alone.
- Controller FSM, counters and output registers stay in led_owner_arbiter.

Test Plan:
All scenarios use NUM_REQ=4, LED_W=4, HOLD_CYCLES=8, HB_HALF_PERIOD=4.
1. Reset and idle: sys_rst high 3 cycles, then req=0 → gnt=0, busy=0; leds toggles 4'b0000/4'b0001 every 4 clocks.
2. Single grant: req=4'b0100, pattern[2]=4'hA → gnt=4'b0100 one clock later; leds=4'hA the clock after; held while req stays high.
3. Hold protection: req[2] granted, req[0] rises at grant+2 → gnt stays 4'b0100 through the 8 hold cycles. Next cycle gnt=0 (one IDLE cycle, heartbeat shown), then gnt=4'b0001.
4. Round-robin: req=4'b1111 continuously → grant order 0,1,2,3,0, each lasting HOLD_CYCLES+1 clocks, separated by one-cycle gnt=0 gaps.
5. Voluntary release in HOLD: req[1] drops 3 cycles after grant → gnt=0 next clock; leds shows heartbeat; no further grant while req=0.
6. Reset mid-ownership: sys_rst pulsed while gnt=4'b1000 → next edge gnt=0, leds=0; after release req=4'b1001 → requester 0 granted first.
